ad_acq_ctrl: RTL
================

AD_ACQ_CTRL -- requirements
Module: ad_acq_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 8, number of discarded cycles after start (0..255).
REQ-002 SHALL have parameter AVG_LOG2, default 4, log2 of samples averaged per channel (N = 2^AVG_LOG2, 1..8).
REQ-003 SHALL have port ad_clk  input  1  acquisition clock (65 MHz).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle acquisition request.
REQ-006 SHALL have port abort  input  1  cancels any acquisition in progress.
REQ-007 SHALL have port cont  input  1  continuous mode: rerun ACCUM after DONE without settling.
REQ-008 SHALL have port volt_ch1  input  16  channel-1 magnitude in mV from the code-to-mV converter.
REQ-009 SHALL have port volt_ch2  input  16  channel-2 magnitude in mV from the code-to-mV converter.
REQ-010 SHALL have port thresh_mv  input  16  over-voltage threshold in mV.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port avg_ch1  output  16  last averaged channel-1 value, mV.
REQ-013 SHALL have port avg_ch2  output  16  last averaged channel-2 value, mV.
REQ-014 SHALL have port avg_valid  output  1  one-cycle pulse when avg_ch1/avg_ch2 update.
REQ-015 SHALL have port over_thresh  output  1  high if either last average is strictly greater than thresh_mv.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, ACCUM, DONE.
REQ-017 IDLE -> SETTLE on start=1 (or IDLE -> ACCUM when SETTLE_CYC=0); start in any non-IDLE state is ignored.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles and discard all samples (covers converter pipeline latency).
REQ-019 ACCUM SHALL last exactly N cycles, adding volt_chX each cycle into a (16+AVG_LOG2)-bit accumulator per channel; no overflow possible.
REQ-020 DONE SHALL last one cycle: avg_chX = acc_chX >> AVG_LOG2 (truncating), avg_valid=1, over_thresh updated from new averages, accumulators and sample counter cleared.
REQ-021 DONE -> ACCUM when cont=1, else DONE -> IDLE.
REQ-022 Start-to-avg_valid latency SHALL be SETTLE_CYC + N + 1 rising edges after the edge capturing start.
REQ-023 In cont mode avg_valid SHALL repeat every N+1 cycles.
REQ-024 abort=1 in any state SHALL force IDLE on the next edge, clear accumulators and counters, suppress avg_valid; avg_chX and over_thresh hold previous values.
REQ-025 abort and start asserted in the same cycle: abort wins, state stays/returns IDLE.
REQ-026 cont deasserted during ACCUM: current window completes, then DONE -> IDLE.
REQ-027 thresh_mv SHALL be sampled only in DONE; changes at other times have no effect until next DONE.
REQ-028 over_thresh with average equal to thresh_mv SHALL be 0.

Reset
REQ-029 rst_n low SHALL asynchronously force state IDLE, busy=0, avg_ch1=0, avg_ch2=0, avg_valid=0, over_thresh=0, accumulators and counters 0.
REQ-030 Reset asserted mid-ACCUM SHALL discard the partial window; no avg_valid after release until a new start.
REQ-031 After rst_n release the block SHALL accept start on the first clock edge.

Structure
REQ-032 Package ad_pkg SHALL hold the FSM state encoding, the mV data width (16) and accumulator-width function (16+AVG_LOG2).
REQ-033 Sub-module ad_avg_acc (one channel: clear, accumulate enable, shifted average output) SHALL be instantiated twice.

Verification
REQ-034 Defaults, volt_ch1=1000, volt_ch2=2000 constant, start pulse -> avg_valid at edge 25 after start, avg_ch1=1000, avg_ch2=2000, busy low after.
REQ-035 volt_ch1 ramp 0..15 across ACCUM -> avg_ch1=7 (sum 120 >> 4).
REQ-036 thresh_mv=1000, constant 1000 -> over_thresh=0; constant 1001 -> over_thresh=1.
REQ-037 volt_ch1=volt_ch2=65535 all window, AVG_LOG2=8 -> avg=65535, no wrap.
REQ-038 abort on 5th ACCUM cycle -> no avg_valid, busy=0 next cycle, previous averages held; start+abort same cycle -> stays IDLE.
REQ-039 cont=1 -> avg_valid pulses every 17 cycles; rst_n low mid-ACCUM -> all outputs 0, no avg_valid until next start.

Source files
------------

// File: rtl/ad_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ad_pkg -- state encoding and data widths for the A/D acquisition controller
// Rev 1.0
// ---------------------------------------------------------------------------
package ad_pkg;

  localparam int c_MV_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } acq_state_t;

  function automatic int acc_width(input int avg_log2);
    return c_MV_W + avg_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ad_avg_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ad_avg_acc -- one-channel sample accumulator with shifted average output
// Rev 1.0
// ---------------------------------------------------------------------------
module ad_avg_acc
  import ad_pkg::*;
#(
  parameter int AVG_LOG2 = 4
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [c_MV_W-1:0] i_din,
  output logic [c_MV_W-1:0] o_avg
);

  localparam int c_ACC_W = acc_width(AVG_LOG2);

  logic [c_ACC_W-1:0] r_acc;

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + c_ACC_W'(i_din);
    end
  end

  // The top c_MV_W bits of the sum are exactly sum >> AVG_LOG2.
  assign o_avg = r_acc[c_ACC_W-1 -: c_MV_W];

endmodule
`default_nettype wire

// File: rtl/ad_acq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ad_acq_ctrl -- settle / accumulate / average controller for two A/D channels
// Rev 1.0
// ---------------------------------------------------------------------------
module ad_acq_ctrl
  import ad_pkg::*;
#(
  parameter int SETTLE_CYC = 8,
  parameter int AVG_LOG2   = 4
) (
  input  logic              ad_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [c_MV_W-1:0] volt_ch1,
  input  logic [c_MV_W-1:0] volt_ch2,
  input  logic [c_MV_W-1:0] thresh_mv,
  output logic              busy,
  output logic [c_MV_W-1:0] avg_ch1,
  output logic [c_MV_W-1:0] avg_ch2,
  output logic              avg_valid,
  output logic              over_thresh
);

  localparam logic [8:0] c_SET_LAST = 9'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [8:0] c_N_LAST   = 9'((1 << AVG_LOG2) - 1);

  acq_state_t        r_state;
  logic [8:0]        r_cnt;
  logic [c_MV_W-1:0] r_avg1;
  logic [c_MV_W-1:0] r_avg2;
  logic              r_valid;
  logic              r_over;

  logic              w_clr;
  logic              w_en;
  logic [c_MV_W-1:0] w_avg1;
  logic [c_MV_W-1:0] w_avg2;

  // Accumulators empty on every DONE so the next window starts from zero.
  assign w_clr = abort || (r_state == ST_DONE);
  assign w_en  = (r_state == ST_ACCUM);

  ad_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc_ch1 (
    .ad_clk (ad_clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_din  (volt_ch1),
    .o_avg  (w_avg1)
  );

  ad_avg_acc #(.AVG_LOG2(AVG_LOG2)) u_acc_ch2 (
    .ad_clk (ad_clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_din  (volt_ch2),
    .o_avg  (w_avg2)
  );

  always_ff @(posedge ad_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_avg1  <= '0;
      r_avg2  <= '0;
      r_valid <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= '0;
            if (start) begin
              r_state <= (SETTLE_CYC == 0) ? ST_ACCUM : ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            if (r_cnt == c_SET_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_ACCUM;
            end else begin
              r_cnt <= r_cnt + 9'd1;
            end
          end
          ST_ACCUM: begin
            if (r_cnt == c_N_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_DONE;
            end else begin
              r_cnt <= r_cnt + 9'd1;
            end
          end
          ST_DONE: begin
            r_avg1  <= w_avg1;
            r_avg2  <= w_avg2;
            r_valid <= 1'b1;
            r_over  <= (w_avg1 > thresh_mv) || (w_avg2 > thresh_mv);
            r_cnt   <= '0;
            r_state <= cont ? ST_ACCUM : ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign busy        = (r_state != ST_IDLE);
  assign avg_ch1     = r_avg1;
  assign avg_ch2     = r_avg2;
  assign avg_valid   = r_valid;
  assign over_thresh = r_over;

endmodule
`default_nettype wire
